// File: rtl/obstacle_collision.sv
// obstacle_collision
//   Once per frame, tests the bee's bounding box against the obstacle's and
//   keeps the hit/lives/invulnerability/game-over bookkeeping.
//
//   Ports
//     Clk        in   system clock, all state on rising edge
//     Reset      in   asynchronous, active-low
//     frame_clk  in   frame strobe, asynchronous to Clk
//     restart    in   synchronous level, reloads game state
//     BeeX/BeeY  in   bee centre        BeeS       in  bee half-size
//     ObsX/ObsY  in   obstacle centre   ObsWidth/ObsHeight in half-extents
//     collide    out  registered raw overlap of last evaluated frame
//     hit        out  one-Clk pulse per accepted hit
//     lives      out  remaining lives
//     invuln     out  high while the immunity counter is nonzero
//     game_over  out  sticky, set when lives reach 0
module obstacle_collision #(
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       restart,
    input  logic [9:0] BeeX,
    input  logic [9:0] BeeY,
    input  logic [9:0] BeeS,
    input  logic [9:0] ObsX,
    input  logic [9:0] ObsY,
    input  logic [9:0] ObsWidth,
    input  logic [9:0] ObsHeight,
    output logic       collide,
    output logic       hit,
    output logic [3:0] lives,
    output logic       invuln,
    output logic       game_over
);

    localparam logic [3:0] LIVES_RST = 4'(LIVES_INIT);
    localparam logic [7:0] INV_LOAD  = 8'(INVULN_FRAMES);

    typedef enum logic [1:0] {IDLE, CAPTURE, COMPARE, UPDATE} state_t;

    typedef struct packed {
        logic [9:0] bee_x;
        logic [9:0] bee_y;
        logic [9:0] bee_s;
        logic [9:0] obs_x;
        logic [9:0] obs_y;
        logic [9:0] obs_w;
        logic [9:0] obs_h;
    } geom_t;

    state_t      state, state_n;
    geom_t       geom;
    logic [2:0]  fsync;
    logic        frame_tick;
    logic        overlap, overlap_q;
    logic [7:0]  inv_cnt;
    logic [10:0] dx, dy, sum_x, sum_y;

    // Two flops for metastability, a third for rising-edge detect.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) fsync <= '0;
        else        fsync <= {fsync[1:0], frame_clk};
    end

    assign frame_tick = fsync[1] & ~fsync[2];

    // |a-b| with both operands zero-extended to 11-bit signed.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic signed [10:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? 11'(-d) : 11'(d);
    endfunction

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_n;
    end

    // Ticks outside IDLE fall through the default and are dropped.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (frame_tick) state_n = CAPTURE;
            CAPTURE: state_n = COMPARE;
            COMPARE: state_n = UPDATE;
            UPDATE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (restart) state_n = IDLE;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            geom <= '0;
        end else if (state == CAPTURE) begin
            geom <= '{bee_x: BeeX, bee_y: BeeY, bee_s: BeeS,
                      obs_x: ObsX, obs_y: ObsY, obs_w: ObsWidth, obs_h: ObsHeight};
        end
    end

    // Sums of two 10-bit values fit in 11 bits; strict compare means
    // touching edges do not count as overlap.
    always_comb begin
        dx      = abs_diff(geom.bee_x, geom.obs_x);
        dy      = abs_diff(geom.bee_y, geom.obs_y);
        sum_x   = {1'b0, geom.bee_s} + {1'b0, geom.obs_w};
        sum_y   = {1'b0, geom.bee_s} + {1'b0, geom.obs_h};
        overlap = (dx < sum_x) && (dy < sum_y);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)                 overlap_q <= 1'b0;
        else if (state == COMPARE)  overlap_q <= overlap;
    end

    // Game bookkeeping. restart takes priority over a same-cycle UPDATE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            collide   <= 1'b0;
            hit       <= 1'b0;
            lives     <= LIVES_RST;
            inv_cnt   <= '0;
            invuln    <= 1'b0;
            game_over <= 1'b0;
        end else if (restart) begin
            collide   <= 1'b0;
            hit       <= 1'b0;
            lives     <= LIVES_RST;
            inv_cnt   <= '0;
            invuln    <= 1'b0;
            game_over <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (state == UPDATE) begin
                collide <= overlap_q;
                if (inv_cnt != '0) begin
                    inv_cnt <= inv_cnt - 8'd1;
                    invuln  <= (inv_cnt != 8'd1);
                end else if (overlap_q && !game_over && lives != '0) begin
                    hit   <= 1'b1;
                    lives <= lives - 4'd1;
                    if (lives == 4'd1) begin
                        // Last life gone: no immunity window, game over sticks.
                        game_over <= 1'b1;
                        inv_cnt   <= '0;
                        invuln    <= 1'b0;
                    end else begin
                        inv_cnt <= INV_LOAD;
                        invuln  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_obstacle_collision.sv
module tb_obstacle_collision;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       restart;
    logic [9:0] BeeX, BeeY, BeeS, ObsX, ObsY, ObsWidth, ObsHeight;
    logic       collide, hit, invuln, game_over;
    logic [3:0] lives;

    int vectors    = 0;
    int miscompares = 0;
    int hits;
    bit hit6;

    obstacle_collision #(.LIVES_INIT(3), .INVULN_FRAMES(60)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .restart(restart),
        .BeeX(BeeX), .BeeY(BeeY), .BeeS(BeeS),
        .ObsX(ObsX), .ObsY(ObsY), .ObsWidth(ObsWidth), .ObsHeight(ObsHeight),
        .collide(collide), .hit(hit), .lives(lives), .invuln(invuln),
        .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_bee(input int bx, input int by, input int bs);
        BeeX = 10'(bx); BeeY = 10'(by); BeeS = 10'(bs);
    endtask

    // One frame strobe. Raised at negedge N0; the tick is seen in the cycle
    // after the 2nd posedge, so outputs update on the 6th posedge and hit
    // is visible at negedge N6. Optionally asserts restart across that edge.
    task automatic do_frame(input bit rst_upd, output int nh, output bit h6);
        nh = 0; h6 = 1'b0;
        frame_clk = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            if (i == 3) frame_clk = 1'b0;
            if (hit) nh++;
            if (i == 6) h6 = hit;
            if (rst_upd && i == 5) restart = 1'b1;
            if (i == 6) restart = 1'b0;
        end
    endtask

    initial begin
        Reset = 1'b0; frame_clk = 1'b0; restart = 1'b0;
        ObsX = 10'd240; ObsY = 10'd242; ObsWidth = 10'd50; ObsHeight = 10'd30;
        set_bee(240, 242, 8);
        repeat (3) @(negedge Clk);
        chk("rst_collide", 32'(collide), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_lives", 32'(lives), 3);
        chk("rst_invuln", 32'(invuln), 0);
        chk("rst_game_over", 32'(game_over), 0);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        // 1: reset while the FSM is in COMPARE with overlapping geometry
        hits = 0;
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        Reset = 1'b0; frame_clk = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) Reset = 1'b1;
            @(negedge Clk);
            if (hit) hits++;
        end
        chk("t1_hits", 32'(hits), 0);
        chk("t1_lives", 32'(lives), 3);
        chk("t1_game_over", 32'(game_over), 0);
        chk("t1_collide", 32'(collide), 0);

        // 2: far apart
        set_bee(100, 100, 8);
        do_frame(1'b0, hits, hit6);
        chk("t2_collide", 32'(collide), 0);
        chk("t2_hits", 32'(hits), 0);
        chk("t2_lives", 32'(lives), 3);

        // 3: overlap, hit, 60 immune frames, hit again on 62nd
        set_bee(240, 242, 8);
        do_frame(1'b0, hits, hit6);
        chk("t3_hit_at_T3", 32'(hit6), 1);
        chk("t3_hit_once", 32'(hits), 1);
        chk("t3_lives", 32'(lives), 2);
        chk("t3_invuln", 32'(invuln), 1);
        chk("t3_collide", 32'(collide), 1);
        for (int f = 1; f <= 60; f++) begin
            do_frame(1'b0, hits, hit6);
            if (hits != 0) chk("t3_immune_hit", 32'(hits), 0);
            if (f == 59) chk("t3_invuln_f59", 32'(invuln), 1);
        end
        chk("t3_invuln_f60", 32'(invuln), 0);
        chk("t3_lives_f60", 32'(lives), 2);
        do_frame(1'b0, hits, hit6);
        chk("t3_hit2", 32'(hits), 1);
        chk("t3_lives2", 32'(lives), 1);

        // 4: edge touch vs one-pixel overlap (immunity active, collide still updates)
        set_bee(182, 242, 8);
        do_frame(1'b0, hits, hit6);
        chk("t4_touch_x", 32'(collide), 0);
        set_bee(183, 242, 8);
        do_frame(1'b0, hits, hit6);
        chk("t4_over_x", 32'(collide), 1);
        chk("t4_no_hit", 32'(hits), 0);
        set_bee(240, 204, 8);
        do_frame(1'b0, hits, hit6);
        chk("t4_touch_y", 32'(collide), 0);

        // 5: run out the remaining 57 immune frames, then lose the last life
        set_bee(240, 242, 8);
        for (int f = 0; f < 57; f++) begin
            do_frame(1'b0, hits, hit6);
            if (hits != 0) chk("t5_immune_hit", 32'(hits), 0);
        end
        chk("t5_invuln_off", 32'(invuln), 0);
        do_frame(1'b0, hits, hit6);
        chk("t5_last_hit", 32'(hits), 1);
        chk("t5_lives0", 32'(lives), 0);
        chk("t5_game_over", 32'(game_over), 1);
        chk("t5_invuln0", 32'(invuln), 0);
        do_frame(1'b0, hits, hit6);
        do_frame(1'b0, hits, hit6);
        chk("t5_no_more_hits", 32'(hits), 0);
        chk("t5_lives_hold", 32'(lives), 0);
        chk("t5_go_sticky", 32'(game_over), 1);
        chk("t5_collide_go", 32'(collide), 1);
        restart = 1'b1;
        @(negedge Clk);
        restart = 1'b0;
        chk("t5_rs_lives", 32'(lives), 3);
        chk("t5_rs_game_over", 32'(game_over), 0);
        chk("t5_rs_invuln", 32'(invuln), 0);
        chk("t5_rs_collide", 32'(collide), 0);

        // 6: restart on the UPDATE edge wins over the overlap hit
        do_frame(1'b1, hits, hit6);
        chk("t6_hits", 32'(hits), 0);
        chk("t6_lives", 32'(lives), 3);
        chk("t6_invuln", 32'(invuln), 0);
        // FSM back in IDLE: next frame hits with normal latency
        do_frame(1'b0, hits, hit6);
        chk("t6_next_hit", 32'(hit6), 1);
        chk("t6_next_lives", 32'(lives), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
